// File: rtl/mdma_param_bwe_ram.sv
// rtl/mdma_param_bwe_ram.sv - lane-enabled single-port-pair RAM with self-init and optional error-injection tags (MDMA_RAM_ERR_INJ_EN)
module mdma_param_bwe_ram #(
  parameter  int DATA_BITS = 128,
  parameter  int DEPTH     = 2048,
  parameter  int WE_BITS   = 16,
  parameter  int RD_LAT    = 1,
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wen,
  input  logic [AW-1:0]        wadr,
  input  logic [WE_BITS-1:0]   wbe,
  input  logic [DATA_BITS-1:0] wdat,
  input  logic                 inj_sbe,
  input  logic                 inj_dbe,
  input  logic                 ren,
  input  logic [AW-1:0]        radr,
  output logic [DATA_BITS-1:0] rdat,
  output logic                 rvld,
  output logic                 rsbe,
  output logic                 rdbe,
  output logic                 init_done,
  output logic [15:0]          sbe_cnt,
  output logic [15:0]          dbe_cnt
);

  localparam int LW = DATA_BITS / WE_BITS;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  // Addresses are compared one bit wider so a non-power-of-two DEPTH can be range-checked.
  localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADR = AW'(DEPTH - 1);

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] init_adr_q, init_adr_d;
  logic          ready;
  logic          wr_ok;
  logic          rd_req;
  logic          rd_in_range;
  logic          rd_sbe;
  logic          rd_dbe;

  logic [DATA_BITS-1:0] mem [DEPTH];

  logic                 s1_vld_q;
  logic [DATA_BITS-1:0] s1_dat_q;
  logic                 s1_sbe_q;
  logic                 s1_dbe_q;

  logic                 out_vld;
  logic [DATA_BITS-1:0] out_dat;
  logic                 out_sbe;
  logic                 out_dbe;

  assign ready       = (state_q == ST_READY);
  assign init_done   = ready;
  assign wr_ok       = ready && wen && ({1'b0, wadr} < DEPTH_W);
  assign rd_req      = ready && ren;
  assign rd_in_range = ({1'b0, radr} < DEPTH_W);

  // Init sweep: walk every address once, then park in READY until the next reset.
  always_comb begin
    state_d    = state_q;
    init_adr_d = init_adr_q;
    if (state_q == ST_INIT) begin
      if (init_adr_q == LAST_ADR) begin
        state_d    = ST_READY;
        init_adr_d = '0;
      end else begin
        init_adr_d = init_adr_q + 1'b1;
      end
    end
  end

  // State and init-address registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_adr_q <= '0;
    end else begin
      state_q    <= state_d;
      init_adr_q <= init_adr_d;
    end
  end

  // Data array: zero-fill during init, lane-masked writes once ready.
  always_ff @(posedge clk) begin
    if (!ready) begin
      mem[init_adr_q] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < WE_BITS; i++) begin
        if (wbe[i]) begin
          mem[wadr][i*LW +: LW] <= wdat[i*LW +: LW];
        end
      end
    end
  end

`ifdef MDMA_RAM_ERR_INJ_EN
  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_SBE  = 2'd1;
  localparam logic [1:0] TAG_DBE  = 2'd2;

  logic [1:0] tag_mem [DEPTH];
  logic [1:0] rd_tag;

  // Tag array: cleared by the init sweep; any lane write retags the entry, DBE winning over SBE.
  always_ff @(posedge clk) begin
    if (!ready) begin
      tag_mem[init_adr_q] <= TAG_NONE;
    end else if (wr_ok && (|wbe)) begin
      if (inj_dbe) begin
        tag_mem[wadr] <= TAG_DBE;
      end else if (inj_sbe) begin
        tag_mem[wadr] <= TAG_SBE;
      end else begin
        tag_mem[wadr] <= TAG_NONE;
      end
    end
  end

  assign rd_tag = rd_in_range ? tag_mem[radr] : TAG_NONE;
  assign rd_sbe = (rd_tag == TAG_SBE);
  assign rd_dbe = (rd_tag == TAG_DBE);
`else
  logic unused_inj;
  assign unused_inj = inj_sbe ^ inj_dbe;
  assign rd_sbe     = 1'b0;
  assign rd_dbe     = 1'b0;
`endif

  // First read stage: sampled before this edge's write lands, so same-address access is read-first.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_dat_q <= '0;
      s1_sbe_q <= 1'b0;
      s1_dbe_q <= 1'b0;
    end else begin
      s1_vld_q <= rd_req;
      if (rd_req) begin
        if (rd_in_range) begin
          s1_dat_q <= mem[radr] ^ {{(DATA_BITS-1){1'b0}}, rd_dbe};
        end else begin
          s1_dat_q <= '0;
        end
        s1_sbe_q <= rd_sbe;
        s1_dbe_q <= rd_dbe;
      end
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic                 s2_vld_q;
    logic [DATA_BITS-1:0] s2_dat_q;
    logic                 s2_sbe_q;
    logic                 s2_dbe_q;

    // Second read stage: data only moves with a valid beat so rdat holds between reads.
    always_ff @(posedge clk) begin
      if (rst) begin
        s2_vld_q <= 1'b0;
        s2_dat_q <= '0;
        s2_sbe_q <= 1'b0;
        s2_dbe_q <= 1'b0;
      end else begin
        s2_vld_q <= s1_vld_q;
        if (s1_vld_q) begin
          s2_dat_q <= s1_dat_q;
          s2_sbe_q <= s1_sbe_q;
          s2_dbe_q <= s1_dbe_q;
        end
      end
    end

    assign out_vld = s2_vld_q;
    assign out_dat = s2_dat_q;
    assign out_sbe = s2_sbe_q;
    assign out_dbe = s2_dbe_q;
  end else begin : g_lat1
    assign out_vld = s1_vld_q;
    assign out_dat = s1_dat_q;
    assign out_sbe = s1_sbe_q;
    assign out_dbe = s1_dbe_q;
  end

  assign rvld = out_vld;
  assign rdat = out_dat;
  assign rsbe = out_vld & out_sbe;
  assign rdbe = out_vld & out_dbe;

`ifdef MDMA_RAM_ERR_INJ_EN
  logic [15:0] sbe_cnt_q;
  logic [15:0] dbe_cnt_q;

  // Saturating error counters, one count per flagged read beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      sbe_cnt_q <= '0;
      dbe_cnt_q <= '0;
    end else begin
      if (rsbe && (sbe_cnt_q != 16'hFFFF)) begin
        sbe_cnt_q <= sbe_cnt_q + 16'd1;
      end
      if (rdbe && (dbe_cnt_q != 16'hFFFF)) begin
        dbe_cnt_q <= dbe_cnt_q + 16'd1;
      end
    end
  end

  assign sbe_cnt = sbe_cnt_q;
  assign dbe_cnt = dbe_cnt_q;
`else
  assign sbe_cnt = 16'h0000;
  assign dbe_cnt = 16'h0000;
`endif

endmodule
